// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M constants: ALUControl M-op codes and the muldiv FSM state encoding.
// Decode and the main ALU import the same codes.
package muldiv_unit_pkg;

   localparam logic [4:0] ALU_MUL    = 5'b10000;
   localparam logic [4:0] ALU_MULH   = 5'b10001;
   localparam logic [4:0] ALU_MULHSU = 5'b10010;
   localparam logic [4:0] ALU_MULHU  = 5'b10011;
   localparam logic [4:0] ALU_DIV    = 5'b10100;
   localparam logic [4:0] ALU_DIVU   = 5'b10101;
   localparam logic [4:0] ALU_REM    = 5'b10110;
   localparam logic [4:0] ALU_REMU   = 5'b10111;

   localparam logic [1:0] M_OP_PREFIX = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_m_op(input logic [4:0] ctrl);
      return ctrl[4:3] == M_OP_PREFIX;
   endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative 32-bit unsigned restoring divider, one quotient bit per cycle.
// last is high in the final iteration cycle, where quotient/remainder carry the finished values.
module div_restoring_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        kill,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        last,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        active_reg;
   logic [4:0]  cnt_reg;
   logic [31:0] dvd_reg;
   logic [31:0] dsr_reg;
   logic [32:0] rem_reg;

   logic [32:0] rem_shift;
   logic [33:0] diff;
   logic        ge;
   logic [32:0] rem_next;
   logic [31:0] dvd_next;

   always_comb begin
      rem_shift = {rem_reg[31:0], dvd_reg[31]};
      diff      = {1'b0, rem_shift} - {2'b00, dsr_reg};
      // A set top bit means the shifted remainder already exceeds any 32-bit divisor.
      ge        = rem_reg[32] | ~diff[33];
      rem_next  = ge ? diff[32:0] : rem_shift;
      dvd_next  = {dvd_reg[30:0], ge};
   end

   assign last      = active_reg & (cnt_reg == 5'd0);
   assign quotient  = dvd_next;
   assign remainder = rem_next[31:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_reg <= 1'b0;
         cnt_reg    <= 5'd0;
         dvd_reg    <= '0;
         dsr_reg    <= '0;
         rem_reg    <= '0;
      end else if (kill) begin
         active_reg <= 1'b0;
         cnt_reg    <= 5'd0;
      end else if (start) begin
         active_reg <= 1'b1;
         cnt_reg    <= 5'd31;
         dvd_reg    <= dividend;
         dsr_reg    <= divisor;
         rem_reg    <= '0;
      end else if (active_reg) begin
         dvd_reg <= dvd_next;
         rem_reg <= rem_next;
         cnt_reg <= cnt_reg - 5'd1;
         if (cnt_reg == 5'd0)
            active_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execution unit: single-cycle multiply, 32-cycle restoring divide with sign fix-up,
// divide special cases resolved at accept, pipeline stall and one-cycle done pulse.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   input  logic [4:0]      alu_control_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   state_t      state_reg;
   logic [2:0]  funct3_reg;
   logic [32:0] mul_a_reg;
   logic [32:0] mul_b_reg;
   logic        q_neg_reg;
   logic        r_neg_reg;
   logic [31:0] result_reg;
   logic        done_reg;
   logic        busy_reg;

   logic        is_m;
   logic        accept;
   logic [2:0]  funct3;
   logic        sign_a;
   logic        sign_b;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic        div_zero;
   logic        div_ovf;
   logic        special;
   logic [31:0] special_result;

   logic [63:0] mul_a_ext;
   logic [63:0] mul_b_ext;
   logic [63:0] product;
   logic [31:0] mul_result;

   logic        div_start;
   logic        div_last;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic [31:0] div_result;

   assign is_m   = is_m_op(alu_control_i);
   assign funct3 = alu_control_i[2:0];
   assign accept = (state_reg == ST_IDLE) & in_valid_i & is_m & ~flush_i;

   // Divides are signed for DIV/REM; multiplies sign rs1 for MULH/MULHSU and rs2 for MULH.
   always_comb begin
      if (funct3[2]) begin
         sign_a = ~funct3[0];
         sign_b = ~funct3[0];
      end else begin
         sign_a = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
         sign_b = (funct3[1:0] == 2'b01);
      end
      neg_a    = sign_a & op_a_i[31];
      neg_b    = sign_b & op_b_i[31];
      abs_a    = neg_a ? (32'd0 - op_a_i) : op_a_i;
      abs_b    = neg_b ? (32'd0 - op_b_i) : op_b_i;
      div_zero = (op_b_i == 32'd0);
      div_ovf  = sign_a && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
      special  = funct3[2] & (div_zero | div_ovf);
      if (div_zero)
         special_result = funct3[1] ? op_a_i : 32'hFFFF_FFFF;
      else
         special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
   end

   always_comb begin
      mul_a_ext  = {{31{mul_a_reg[32]}}, mul_a_reg};
      mul_b_ext  = {{31{mul_b_reg[32]}}, mul_b_reg};
      product    = mul_a_ext * mul_b_ext;
      mul_result = (funct3_reg == 3'b000) ? product[31:0] : product[63:32];
   end

   assign div_start = accept & funct3[2] & ~special;

   div_restoring_core u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .kill      (flush_i),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .last      (div_last),
      .quotient  (div_quot),
      .remainder (div_rem)
   );

   always_comb begin
      if (funct3_reg[1])
         div_result = r_neg_reg ? (32'd0 - div_rem) : div_rem;
      else
         div_result = q_neg_reg ? (32'd0 - div_quot) : div_quot;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         funct3_reg <= 3'b000;
         mul_a_reg  <= '0;
         mul_b_reg  <= '0;
         q_neg_reg  <= 1'b0;
         r_neg_reg  <= 1'b0;
         result_reg <= '0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  funct3_reg <= funct3;
                  if (!funct3[2]) begin
                     mul_a_reg <= {sign_a & op_a_i[31], op_a_i};
                     mul_b_reg <= {sign_b & op_b_i[31], op_b_i};
                     state_reg <= ST_MUL;
                     busy_reg  <= 1'b1;
                  end else if (special) begin
                     result_reg <= special_result;
                     state_reg  <= ST_DONE;
                     done_reg   <= 1'b1;
                  end else begin
                     q_neg_reg <= neg_a ^ neg_b;
                     r_neg_reg <= neg_a;
                     state_reg <= ST_DIV;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               busy_reg <= 1'b0;
               if (flush_i) begin
                  state_reg <= ST_IDLE;
               end else begin
                  result_reg <= mul_result;
                  state_reg  <= ST_DONE;
                  done_reg   <= 1'b1;
               end
            end
            ST_DIV: begin
               if (flush_i) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end else if (div_last) begin
                  result_reg <= div_result;
                  state_reg  <= ST_DONE;
                  done_reg   <= 1'b1;
                  busy_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o   = busy_reg;
   assign done_o   = done_reg;
   assign result_o = result_reg;
   assign stall_o  = in_valid_i & is_m & ~done_reg;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execution unit in the EX stage of each core. Consumes the 5-bit ALUControl code from the decode stage, plus the two operands. Computes MUL/MULH/MULHSU/MULHU in one cycle and DIV/DIVU/REM/REMU with a 32-iteration restoring divider. Raises a stall request while busy and returns a 32-bit result with a one-cycle done pulse. Non-M ALUControl codes are ignored and handled by the main ALU.

## Interface
- Parameters:
- XLEN, 32: operand/result width; only 32 is supported.
- Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  EX stage holds a valid instruction this cycle.
- alu_control_i  in  5  ALUControl from decode; M ops are 5'b10000–5'b10111, with low 3 bits = funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- op_a_i  in  32  rs1 operand (post-forwarding).
- op_b_i  in  32  rs2 operand (post-forwarding).
- flush_i  in  1  kill the in-flight operation (branch mispredict/trap).
- stall_o  out  1  hold IF/ID/EX; equals in_valid_i & is_m & ~done_o.
- busy_o  out  1  state is MUL or DIV.
- done_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  32  result; held until the next accept or reset.

## Operation
- is_m = alu_control_i[4:3] == 2'b10.
- Accept: in IDLE with in_valid_i & is_m & ~flush_i. Latch op, operands, operand signs and the funct3 code.
- FSM states:
- IDLE: waits for accept.
- MUL: entered on accept of funct3[2]=0.
- DIV: entered on accept of funct3[2]=1 when no special case applies.
- DONE: one cycle, done_o=1, then IDLE.
- Multiply:
- Form 33-bit extended operands. rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only.
- Compute the 66-bit signed product.
- MUL returns bits[31:0]; the others return bits[63:32].
- Result is written in the MUL cycle; DONE follows.
- Divide:
- For signed ops, take absolute values; remember quotient sign (sa^sb) and remainder sign (sa).
- 32 iterations, one per cycle, tracked by a 5-bit counter counting down from 31.
- Each iteration: rem = {rem[31:0], dvd[31]}; if rem ≥ divisor, subtract and shift in 1, else shift in 0.
- The remainder register is 33 bits.
- In the last iteration cycle, apply sign correction and write result_o.
- Special cases are resolved at accept and go straight to DONE:
- Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Back-to-back operations:
- A new accept is legal in the cycle after DONE (the state is IDLE).
- The pipeline advances on the done cycle, so the same instruction is never re-accepted.
- flush_i in any state: next state IDLE, no done_o, result_o unchanged. flush_i in the accept cycle suppresses the accept.
- in_valid_i with a non-M code: no state change, stall_o=0.

## Timing
- Reset values: state IDLE, counter 0, result_o 0, done_o 0, busy_o 0; stall_o follows its combinational equation.
- Multiply latency: accept at cycle N, MUL at N+1, done_o at N+2. stall_o is high in cycles N and N+1.
- Divide latency: accept at N, DIV for N+1..N+32, done_o at N+33. 33 stall cycles.
- Special-case divide: done_o at N+1.
- Reset asserted mid-operation: immediate return to reset values with no done pulse.

## Structure
- Shared package/header holds the ALUControl M-op localparams (ALU_MUL … ALU_REMU) and the state encoding. The decode and ALU modules use the same constants.
- One natural sub-module, `div_restoring_core`: the iterative unsigned divider plus counter, with a start/done handshake. The wrapper handles sign handling, special cases and the multiply.

## Test plan
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU on the same operands → 0xFFFFFFFE. MUL on the same operands → 0x00000001. Each gives done_o at N+2.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. Each gives done_o at N+33, with stall_o high for exactly 33 cycles.
- DIVU 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000. REM on the same operands → 0. Each gives done_o at N+1.
- flush_i at iteration 10 of a DIV → IDLE next cycle, no done_o. An immediately following MUL 3×4 → 12 at N+2.
- Back-to-back: MUL then DIVU 9/3 accepted the cycle after DONE → results 12 and 3, each done pulsed once.
- Async rst asserted mid-DIV (between clock edges) → outputs at reset values immediately, no done_o. A new op after release completes normally.
